// File: rtl/ex_result_stage.sv
// EX/MEM result register with Z/V/N flag update, stall/flush, sticky halt
// and a saturating retired-instruction counter.
module ex_result_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_ovfl,
    input  logic [3:0]        in_dst,
    input  logic              in_wr_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_dst,
    output logic              out_wr_en,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpXor = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpRor = 4'b0110;
    localparam logic [3:0] OpHlt = 4'b1111;

    typedef enum logic {RUN, HALT} stateT;
    stateT state, nextState;

    logic accept;
    logic isArith;
    logic isZeroOnly;
    logic isHlt;
    logic resultZero;

    assign accept     = in_valid & ~stall & ~flush & (state == RUN);
    assign isArith    = (in_opcode == OpAdd) || (in_opcode == OpSub);
    assign isZeroOnly = (in_opcode == OpXor) || (in_opcode == OpSll) ||
                        (in_opcode == OpSra) || (in_opcode == OpRor);
    assign isHlt      = (in_opcode == OpHlt);
    assign resultZero = (in_result == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= nextState;
    end

    // accept already excludes stall, flush and HALT
    always_comb begin
        nextState = state;
        if (accept && isHlt) nextState = HALT;
    end

    always_comb begin
        halted = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_dst    <= '0;
            out_wr_en  <= 1'b0;
        end else if (flush || (!stall && state == HALT)) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_dst    <= '0;
            out_wr_en  <= 1'b0;
        end else if (!stall) begin
            out_valid  <= accept;
            out_result <= in_result;
            out_dst    <= in_dst;
            out_wr_en  <= in_wr_en & accept & ~isHlt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept) begin
            if (isArith) begin
                flag_z <= resultZero;
                flag_n <= in_result[DATA_W-1];
                flag_v <= in_ovfl;
            end else if (isZeroOnly) begin
                flag_z <= resultZero;
            end
        end
    end

    // saturate instead of wrapping so long runs never look short
    always_ff @(posedge clk) begin
        if (rst)                            retired <= '0;
        else if (accept && retired != '1)   retired <= retired + CNT_W'(1);
    end
endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage; a second CNT_W=2 instance shares the
// stimulus to exercise counter saturation.
module tb_ex_result_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, inValid, inOvfl, inWrEn;
    logic [3:0]  inOpcode, inDst;
    logic [15:0] inResult;

    logic        outValid, outWrEn, flagZ, flagV, flagN, halted;
    logic [15:0] outResult, retired;
    logic [3:0]  outDst;

    logic        sOutValid, sOutWrEn, sFlagZ, sFlagV, sFlagN, sHalted;
    logic [15:0] sOutResult;
    logic [3:0]  sOutDst;
    logic [1:0]  sRetired;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    ex_result_stage #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_opcode(inOpcode), .in_result(inResult),
        .in_ovfl(inOvfl), .in_dst(inDst), .in_wr_en(inWrEn),
        .out_valid(outValid), .out_result(outResult), .out_dst(outDst),
        .out_wr_en(outWrEn), .flag_z(flagZ), .flag_v(flagV), .flag_n(flagN),
        .halted(halted), .retired(retired)
    );

    ex_result_stage #(.DATA_W(16), .CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_opcode(inOpcode), .in_result(inResult),
        .in_ovfl(inOvfl), .in_dst(inDst), .in_wr_en(inWrEn),
        .out_valid(sOutValid), .out_result(sOutResult), .out_dst(sOutDst),
        .out_wr_en(sOutWrEn), .flag_z(sFlagZ), .flag_v(sFlagV), .flag_n(sFlagN),
        .halted(sHalted), .retired(sRetired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                         input logic [3:0] dst, input logic wr);
        inValid = 1'b1; inOpcode = op; inResult = res; inOvfl = ovfl; inDst = dst; inWrEn = wr;
    endtask

    task automatic chkFlags(input string tag, input logic z, input logic v, input logic n);
        chk({tag, ".z"}, {31'd0, flagZ}, {31'd0, z});
        chk({tag, ".v"}, {31'd0, flagV}, {31'd0, v});
        chk({tag, ".n"}, {31'd0, flagN}, {31'd0, n});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        inValid = 1'b0; inOpcode = 4'h0; inResult = 16'h0; inOvfl = 1'b0; inDst = 4'h0; inWrEn = 1'b0;
        step();
        chk("rst.valid", {31'd0, outValid}, 32'd0);
        chk("rst.result", {16'd0, outResult}, 32'd0);
        chk("rst.retired", {16'd0, retired}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chkFlags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // ADD 0x8000 with overflow
        drive(4'h0, 16'h8000, 1'b1, 4'd3, 1'b1); step();
        chk("add.result", {16'd0, outResult}, 32'h8000);
        chk("add.valid", {31'd0, outValid}, 32'd1);
        chk("add.dst", {28'd0, outDst}, 32'd3);
        chk("add.wren", {31'd0, outWrEn}, 32'd1);
        chkFlags("add", 1'b0, 1'b1, 1'b1);
        chk("add.retired", {16'd0, retired}, 32'd1);

        // SUB 0 then XOR 5: V/N hold across XOR
        drive(4'h1, 16'h0000, 1'b0, 4'd4, 1'b1); step();
        chkFlags("sub", 1'b1, 1'b0, 1'b0);
        drive(4'h2, 16'h0005, 1'b1, 4'd5, 1'b1); step();
        chkFlags("xor", 1'b0, 1'b0, 1'b0);
        chk("xor.retired", {16'd0, retired}, 32'd3);
        chk("small.sat3", {30'd0, sRetired}, 32'd3);

        // SUB 0 then RED 0xFF80: RED leaves flags alone
        drive(4'h1, 16'h0000, 1'b0, 4'd4, 1'b1); step();
        chk("small.sat4", {30'd0, sRetired}, 32'd3);
        drive(4'h3, 16'hFF80, 1'b1, 4'd6, 1'b1); step();
        chk("red.result", {16'd0, outResult}, 32'hFF80);
        chk("red.wren", {31'd0, outWrEn}, 32'd1);
        chkFlags("red", 1'b1, 1'b0, 1'b0);
        chk("red.retired", {16'd0, retired}, 32'd5);

        // SLL nonzero clears Z, then ADD 0 held under a 2-cycle stall
        drive(4'h4, 16'h0001, 1'b0, 4'd7, 1'b1); step();
        chkFlags("sll", 1'b0, 1'b0, 1'b0);
        drive(4'h0, 16'h0000, 1'b0, 4'd8, 1'b1);
        stall = 1'b1; step(); step();
        chk("stall.result", {16'd0, outResult}, 32'h0001);
        chk("stall.dst", {28'd0, outDst}, 32'd7);
        chk("stall.retired", {16'd0, retired}, 32'd6);
        chkFlags("stall", 1'b0, 1'b0, 1'b0);
        stall = 1'b0; step();
        chkFlags("unstall", 1'b1, 1'b0, 1'b0);
        chk("unstall.retired", {16'd0, retired}, 32'd7);
        chk("unstall.dst", {28'd0, outDst}, 32'd8);

        // invalid slot
        inValid = 1'b0; step();
        chk("bubble.valid", {31'd0, outValid}, 32'd0);
        chk("bubble.wren", {31'd0, outWrEn}, 32'd0);
        chk("bubble.retired", {16'd0, retired}, 32'd7);

        // flushed HLT does not halt
        drive(4'hF, 16'h1234, 1'b0, 4'd9, 1'b1); flush = 1'b1; step();
        chk("flushhlt.halted", {31'd0, halted}, 32'd0);
        chk("flushhlt.valid", {31'd0, outValid}, 32'd0);
        chk("flushhlt.result", {16'd0, outResult}, 32'd0);
        chk("flushhlt.retired", {16'd0, retired}, 32'd7);
        flush = 1'b0; step();
        chk("hlt.halted", {31'd0, halted}, 32'd1);
        chk("hlt.valid", {31'd0, outValid}, 32'd1);
        chk("hlt.wren", {31'd0, outWrEn}, 32'd0);
        chk("hlt.retired", {16'd0, retired}, 32'd8);

        // ADD while halted is ignored
        drive(4'h0, 16'h8000, 1'b1, 4'd2, 1'b1); step();
        chk("halt.valid", {31'd0, outValid}, 32'd0);
        chk("halt.result", {16'd0, outResult}, 32'd0);
        chk("halt.retired", {16'd0, retired}, 32'd8);
        chk("halt.sticky", {31'd0, halted}, 32'd1);
        chkFlags("halt", 1'b1, 1'b0, 1'b0);

        // reset beats stall/flush/HALT
        rst = 1'b1; stall = 1'b1; flush = 1'b1; step();
        chk("rst2.halted", {31'd0, halted}, 32'd0);
        chk("rst2.retired", {16'd0, retired}, 32'd0);
        chk("rst2.small", {30'd0, sRetired}, 32'd0);
        chkFlags("rst2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(4'h0, 16'h0002, 1'b0, 4'd1, 1'b1); step();
        chk("run.valid", {31'd0, outValid}, 32'd1);
        chk("run.result", {16'd0, outResult}, 32'h0002);
        chk("run.retired", {16'd0, retired}, 32'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
